shift_arb_ctrl: RTL and testbench

SHIFT_ARB_CTRL -- requirements
Module: shift_arb_ctrl

---
 rtl/shift_arb_ctrl_pkg.sv | 12 +
 rtl/shift_reg_piso.sv | 30 +++
 rtl/shift_arb_ctrl.sv | 109 ++++++++++
 tb/tb_shift_arb_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_ctrl_pkg.sv
// Shared types and constants for the two-requester serialising arbiter.
package shift_arb_ctrl_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register: load has priority, shifts left with
// zero fill, MSB is the serial output.
module shift_reg_piso
  import shift_arb_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/shift_arb_ctrl.sv
// Round-robin arbiter between two requesters that serialises the winner's
// word MSB first and pulses the winner's ack after the last bit.
module shift_arb_ctrl
  import shift_arb_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic             out,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             winner, winner_nxt;
  logic             last, last_nxt;
  logic             grant_sel;
  logic             load, shift_en, msb;
  logic [WIDTH-1:0] load_data;

  // On a tie the requester not granted last wins; otherwise the lone requester.
  always_comb begin
    if (req0 && req1) begin
      grant_sel = ~last;
    end else begin
      grant_sel = req1;
    end
    load_data = grant_sel ? data1 : data0;
  end

  shift_reg_piso #(.WIDTH(WIDTH)) u_piso (
    .clk    (clk),
    .resetn (resetn),
    .load   (load),
    .shift  (shift_en),
    .din    (load_data),
    .msb    (msb)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      winner <= 1'b0;
      last   <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      winner <= winner_nxt;
      last   <= last_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    winner_nxt = winner;
    last_nxt   = last;
    load       = 1'b0;
    shift_en   = 1'b0;
    out        = 1'b0;
    out_valid  = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req0 || req1) begin
          load       = 1'b1;
          winner_nxt = grant_sel;
          cnt_nxt    = CW'(WIDTH - 1);
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        out       = msb;
        out_valid = 1'b1;
        shift_en  = 1'b1;
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE: begin
        ack0      = ~winner;
        ack1      = winner;
        last_nxt  = winner;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Directed bench for shift_arb_ctrl (WIDTH=8 and WIDTH=4 instances).
module tb_shift_arb_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       ack0, ack1, out, out_valid, busy;

  logic       r4_0, r4_1;
  logic [3:0] d4_0, d4_1;
  logic       a4_0, a4_1, o4, ov4, b4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_arb_ctrl u_dut (
    .clk(clk), .resetn(resetn),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .ack0(ack0), .ack1(ack1), .out(out), .out_valid(out_valid), .busy(busy)
  );

  shift_arb_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .resetn(resetn),
    .req0(r4_0), .data0(d4_0), .req1(r4_1), .data1(d4_1),
    .ack0(a4_0), .ack1(a4_1), .out(o4), .out_valid(ov4), .busy(b4)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    r4_0 = 1'b0; r4_1 = 1'b0; d4_0 = '0; d4_1 = '0;
    step; step;
    n_cmp++;
    if ({out, out_valid, ack0, ack1, busy} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_outputs got %b want 00000", {out, out_valid, ack0, ack1, busy});
    end
    n_cmp++;
    if ({o4, ov4, a4_0, a4_1, b4} !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_outputs_w4 got %b want 00000", {o4, ov4, a4_0, a4_1, b4});
    end
    resetn = 1'b1;
    step;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle_no_req got busy=%b want 0", busy);
    end
  endtask

  task automatic test_single;
    logic [7:0] pat = 8'hA5;
    logic [4:0] got, want;
    req0 = 1'b1; data0 = 8'hA5;
    step;
    for (int i = 0; i < 8; i++) begin
      got  = {out_valid, out, ack0, ack1, busy};
      want = {1'b1, pat[7-i], 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL single_bit%0d got %b want %b", i, got, want);
      end
      step;
    end
    n_cmp++;
    if ({out_valid, out, ack0, ack1, busy} !== 5'b00101) begin
      n_bad++;
      $display("FAIL single_ack0 got %b want 00101", {out_valid, out, ack0, ack1, busy});
    end
    req0 = 1'b0;
    step;
    n_cmp++;
    if ({ack0, ack1, busy, out_valid} !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_back_idle got %b want 0000", {ack0, ack1, busy, out_valid});
    end
  endtask

  task automatic test_tie;
    logic [7:0] pat0 = 8'hF0;
    logic [7:0] pat1 = 8'h0F;
    logic [4:0] got, want;
    resetn = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = 8'hF0; data1 = 8'h0F;
    step;
    resetn = 1'b1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_no_grant_in_reset got busy=%b want 0", busy);
    end
    step;
    for (int i = 0; i < 8; i++) begin
      got  = {out_valid, out, ack0, ack1, busy};
      want = {1'b1, pat0[7-i], 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL tie_first_bit%0d got %b want %b", i, got, want);
      end
      step;
    end
    n_cmp++;
    if ({out_valid, out, ack0, ack1, busy} !== 5'b00101) begin
      n_bad++;
      $display("FAIL tie_first_ack0 got %b want 00101", {out_valid, out, ack0, ack1, busy});
    end
    step;
    n_cmp++;
    if ({busy, out_valid, ack0, ack1} !== 4'b0000) begin
      n_bad++;
      $display("FAIL tie_gap_idle got %b want 0000", {busy, out_valid, ack0, ack1});
    end
    step;
    for (int i = 0; i < 8; i++) begin
      got  = {out_valid, out, ack0, ack1, busy};
      want = {1'b1, pat1[7-i], 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL tie_second_bit%0d got %b want %b", i, got, want);
      end
      step;
    end
    n_cmp++;
    if ({out_valid, out, ack0, ack1, busy} !== 5'b00011) begin
      n_bad++;
      $display("FAIL tie_second_ack1 got %b want 00011", {out_valid, out, ack0, ack1, busy});
    end
    req0 = 1'b0; req1 = 1'b0;
    step;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_back_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat = 8'h3C;
    int rises[$];
    int gap = 0, max_gap = 0, k = 0, n_ack1 = 0, waited = 0;
    bit seen_valid = 1'b0, prev_busy = 1'b0, prev_valid = 1'b0;
    req1 = 1'b1; data1 = 8'h3C;
    for (int c = 0; c < 32; c++) begin
      step;
      if (busy && !prev_busy) rises.push_back(c);
      if (out_valid) begin
        if (!prev_valid) k = 0;
        n_cmp++;
        if (out !== pat[7-k]) begin
          n_bad++;
          $display("FAIL b2b_bit cycle %0d idx %0d got %b want %b", c, k, out, pat[7-k]);
        end
        k++;
        if (seen_valid && gap > max_gap) max_gap = gap;
        gap = 0;
        seen_valid = 1'b1;
      end else if (seen_valid) begin
        gap++;
      end
      n_cmp++;
      if (ack0 !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_no_ack0 cycle %0d got ack0=%b ack1=%b want ack0=0", c, ack0, ack1);
      end
      if (ack1 === 1'b1) n_ack1++;
      prev_busy  = busy;
      prev_valid = out_valid;
    end
    n_cmp++;
    if (rises.size() != 4) begin
      n_bad++;
      $display("FAIL b2b_grant_count got %0d want 4", rises.size());
    end else begin
      for (int j = 1; j < 4; j++) begin
        n_cmp++;
        if (rises[j] - rises[j-1] != 10) begin
          n_bad++;
          $display("FAIL b2b_grant_spacing%0d got %0d want 10", j, rises[j] - rises[j-1]);
        end
      end
    end
    n_cmp++;
    if (max_gap != 2) begin
      n_bad++;
      $display("FAIL b2b_valid_gap got %0d want 2", max_gap);
    end
    n_cmp++;
    if (n_ack1 != 3) begin
      n_bad++;
      $display("FAIL b2b_ack1_count got %0d want 3", n_ack1);
    end
    req1 = 1'b0;
    while (busy === 1'b1 && waited < 20) begin
      step;
      waited++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_drain_timeout got busy=%b want 0", busy);
    end
  endtask

  task automatic test_mid_frame;
    logic [7:0] pat = 8'hA5;
    logic [4:0] got, want;
    req0 = 1'b1; data0 = 8'hA5;
    step;
    for (int i = 0; i < 8; i++) begin
      got  = {out_valid, out, ack0, ack1, busy};
      want = {1'b1, pat[7-i], 1'b0, 1'b0, 1'b1};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL midframe_bit%0d got %b want %b", i, got, want);
      end
      if (i == 3) begin
        data0 = 8'h00;
        req0  = 1'b0;
      end
      step;
    end
    n_cmp++;
    if ({out_valid, out, ack0, ack1, busy} !== 5'b00101) begin
      n_bad++;
      $display("FAIL midframe_ack0 got %b want 00101", {out_valid, out, ack0, ack1, busy});
    end
    step;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_width4;
    logic [3:0] pat = 4'h9;
    logic [3:0] got, want;
    r4_0 = 1'b1; d4_0 = 4'h9;
    step;
    for (int i = 0; i < 4; i++) begin
      got  = {ov4, o4, a4_0, a4_1};
      want = {1'b1, pat[3-i], 1'b0, 1'b0};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL w4_bit%0d got %b want %b", i, got, want);
      end
      step;
    end
    n_cmp++;
    if ({ov4, o4, a4_0, a4_1} !== 4'b0010) begin
      n_bad++;
      $display("FAIL w4_ack0 got %b want 0010", {ov4, o4, a4_0, a4_1});
    end
    r4_0 = 1'b0;
    step;
    n_cmp++;
    if (b4 !== 1'b0) begin
      n_bad++;
      $display("FAIL w4_idle got busy=%b want 0", b4);
    end
  endtask

  task automatic test_reset_midframe;
    req0 = 1'b1; data0 = 8'hFF;
    step; step; step;
    n_cmp++;
    if ({out_valid, busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL rstmid_in_shift got %b want 11", {out_valid, busy});
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if ({out, out_valid, busy, ack0, ack1} !== 5'b00000) begin
      n_bad++;
      $display("FAIL rstmid_immediate got %b want 00000", {out, out_valid, busy, ack0, ack1});
    end
    req0 = 1'b0;
    step;
    resetn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step;
      n_cmp++;
      if ({ack0, ack1, busy, out_valid} !== 4'b0000) begin
        n_bad++;
        $display("FAIL rstmid_no_ack cycle %0d got %b want 0000", c, {ack0, ack1, busy, out_valid});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_back_to_back;
    test_mid_frame;
    test_width4;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
